// File: rtl/wordle_guess_scorer.sv
// Wordle guess scorer: one green (exact-match) pass, then one yellow-search
// cycle per letter in ascending order so duplicate letters consume target
// copies left to right. Outputs are registered; busy/done follow the state
// register by one edge, while done drops on the same edge that accepts ack.
module wordle_guess_scorer #(
  parameter int unsigned LETTERS      = 5,
  parameter logic [2:0]  COLOR_GREEN  = 3'b010,
  parameter logic [2:0]  COLOR_YELLOW = 3'b110,
  parameter logic [2:0]  COLOR_MISS   = 3'b111
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LETTERS*8-1:0] guess,
  input  logic [LETTERS*8-1:0] target,
  input  logic                 ack,
  output logic                 busy,
  output logic                 done,
  output logic [LETTERS*3-1:0] colors,
  output logic                 win
);

  localparam int unsigned IdxW = (LETTERS > 1) ? $clog2(LETTERS) : 1;

  typedef enum logic [1:0] {StIdle, StGreen, StYellow, StDone} state_t;

  state_t               state_q;
  logic [LETTERS*8-1:0] g_q, t_q;
  logic [LETTERS-1:0]   green_q, used_q;
  logic [IdxW-1:0]      idx_q;
  logic [LETTERS*3-1:0] colors_q;
  logic                 win_q, busy_q, done_q;

  logic [7:0]           g_lt [LETTERS];
  logic [7:0]           t_lt [LETTERS];
  logic [LETTERS-1:0]   green_vec;
  logic [LETTERS*3-1:0] colors_grn;
  logic [7:0]           cur_letter;
  logic                 cur_green;
  logic                 found;
  logic [LETTERS-1:0]   consume;
  logic [LETTERS*3-1:0] colors_ylw;

  // Unpack latched words into letters (letter 0 is the most significant byte)
  always_comb begin
    for (int i = 0; i < LETTERS; i++) begin
      g_lt[i] = g_q[(LETTERS-1-i)*8 +: 8];
      t_lt[i] = t_q[(LETTERS-1-i)*8 +: 8];
    end
  end

  // Exact-match pass: green where letters agree, miss everywhere else
  always_comb begin
    green_vec  = '0;
    colors_grn = '0;
    for (int i = 0; i < LETTERS; i++) begin
      green_vec[i] = (g_lt[i] == t_lt[i]);
      colors_grn[(LETTERS-1-i)*3 +: 3] = green_vec[i] ? COLOR_GREEN : COLOR_MISS;
    end
  end

  // Yellow search for the current idx: lowest unused matching target slot
  always_comb begin
    cur_letter = '0;
    cur_green  = 1'b0;
    found      = 1'b0;
    consume    = '0;
    colors_ylw = colors_q;
    for (int i = 0; i < LETTERS; i++) begin
      if (IdxW'(i) == idx_q) begin
        cur_letter = g_lt[i];
        cur_green  = green_q[i];
      end
    end
    for (int j = 0; j < LETTERS; j++) begin
      if (!cur_green && !found && !used_q[j] && (t_lt[j] == cur_letter)) begin
        found      = 1'b1;
        consume[j] = 1'b1;
      end
    end
    for (int i = 0; i < LETTERS; i++) begin
      if ((IdxW'(i) == idx_q) && found) begin
        colors_ylw[(LETTERS-1-i)*3 +: 3] = COLOR_YELLOW;
      end
    end
  end

  // Scoring FSM with registered outputs
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      g_q      <= '0;
      t_q      <= '0;
      green_q  <= '0;
      used_q   <= '0;
      idx_q    <= '0;
      colors_q <= '0;
      win_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_q == StGreen) || (state_q == StYellow);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            g_q      <= guess;
            t_q      <= target;
            colors_q <= '0;
            green_q  <= '0;
            used_q   <= '0;
            idx_q    <= '0;
            state_q  <= StGreen;
          end
        end
        StGreen: begin
          colors_q <= colors_grn;
          green_q  <= green_vec;
          used_q   <= green_vec;
          win_q    <= &green_vec;
          idx_q    <= '0;
          state_q  <= StYellow;
        end
        StYellow: begin
          colors_q <= colors_ylw;
          used_q   <= used_q | consume;
          if (idx_q == IdxW'(LETTERS - 1)) begin
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          // ack only counts once the consumer can actually see done
          if (done_q && ack) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign colors = colors_q;
  assign win    = win_q;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Directed bench for wordle_guess_scorer: scoring rules, latency, handshake
// and mid-score reset.
module tb_wordle_guess_scorer;

  logic        Clk;
  logic        reset_n;
  logic        start;
  logic [39:0] guess;
  logic [39:0] target;
  logic        ack;
  logic        busy;
  logic        done;
  logic [14:0] colors;
  logic        win;

  int n_checks = 0;
  int n_pass   = 0;

  wordle_guess_scorer dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .start   (start),
    .guess   (guess),
    .target  (target),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .colors  (colors),
    .win     (win)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pulse start with g/t, scramble inputs afterwards, count negedges until done
  task automatic do_score(input logic [39:0] g, input logic [39:0] t, output int k);
    @(negedge Clk);
    guess  = g;
    target = t;
    start  = 1'b1;
    @(negedge Clk);
    start  = 1'b0;
    guess  = "ZZZZZ";
    target = "QQQQQ";
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge Clk);
      k++;
    end
  endtask

  task automatic do_ack();
    @(negedge Clk);
    ack = 1'b1;
    @(negedge Clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, win, colors} !== 18'h0)
      $display("FAIL reset_state: busy=%b done=%b win=%b colors=%b, want all 0",
               busy, done, win, colors);
    else n_pass++;
  endtask

  task automatic test_apple();
    int k;
    do_score("PAPER", "APPLE", k);
    n_checks++;
    if (k != 7) $display("FAIL apple_latency: got %0d want 7", k);
    else n_pass++;
    n_checks++;
    if (colors !== 15'b110_110_010_110_111 || win !== 1'b0)
      $display("FAIL apple_colors: got %b win=%b want 110110010110111 win=0", colors, win);
    else n_pass++;
    do_ack();
  endtask

  task automatic test_duplicates();
    int k;
    do_score("BOBBY", "ABBEY", k);
    n_checks++;
    if (colors !== 15'b110_111_010_111_010 || win !== 1'b0)
      $display("FAIL dup_colors: got %b win=%b want 110111010111010 win=0", colors, win);
    else n_pass++;
    do_ack();
  endtask

  task automatic test_win();
    int k;
    do_score("CRANE", "CRANE", k);
    n_checks++;
    if (colors !== 15'b010_010_010_010_010 || win !== 1'b1)
      $display("FAIL win_colors: got %b win=%b want 010010010010010 win=1", colors, win);
    else n_pass++;
    do_ack();
    // Result must persist in IDLE
    n_checks++;
    if (colors !== 15'b010_010_010_010_010 || win !== 1'b1 || done !== 1'b0)
      $display("FAIL win_hold_idle: got %b win=%b done=%b", colors, win, done);
    else n_pass++;
  endtask

  task automatic test_blank_and_case();
    int k;
    do_score("     ", "CRANE", k);
    n_checks++;
    if (colors !== 15'b111_111_111_111_111 || win !== 1'b0)
      $display("FAIL blank_row: got %b win=%b want all 111 win=0", colors, win);
    else n_pass++;
    do_ack();
    do_score("crane", "CRANE", k);
    n_checks++;
    if (colors !== 15'b111_111_111_111_111 || win !== 1'b0)
      $display("FAIL case_sensitive: got %b win=%b want all 111 win=0", colors, win);
    else n_pass++;
    do_ack();
    // Spaces match only spaces: ' ' at tile 1 green, 'A' at 0 yellow
    do_score("A BCD", "X AEF", k);
    n_checks++;
    if (colors !== 15'b110_010_111_111_111)
      $display("FAIL space_match: got %b want 110010111111111", colors);
    else n_pass++;
    do_ack();
  endtask

  task automatic test_timing();
    int bad_timing = 0;
    int bad_hold   = 0;
    logic [14:0] snap;
    @(negedge Clk);
    guess  = "PAPER";
    target = "APPLE";
    start  = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) @(negedge Clk);
      if (busy !== (k >= 1 && k <= 6) || done !== (k >= 7)) begin
        $display("FAIL timing_k%0d: busy=%b done=%b want busy=%b done=%b",
                 k, busy, done, (k >= 1 && k <= 6), (k >= 7));
        bad_timing++;
      end
    end
    n_checks++;
    if (bad_timing != 0) $display("FAIL timing_profile: got %0d bad cycles want 0", bad_timing);
    else n_pass++;
    snap = colors;
    n_checks++;
    if (snap !== 15'b110_110_010_110_111)
      $display("FAIL timing_colors: got %b want 110110010110111", snap);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (done !== 1'b1 || colors !== snap || busy !== 1'b0) bad_hold++;
    end
    n_checks++;
    if (bad_hold != 0) $display("FAIL done_hold: got %0d unstable cycles want 0", bad_hold);
    else n_pass++;
    ack = 1'b1;
    @(negedge Clk);
    ack = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL ack_release: done=%b busy=%b want 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_ignored_handshake();
    int k = 0;
    int extra = 0;
    @(negedge Clk);
    guess  = "BOBBY";
    target = "ABBEY";
    start  = 1'b1;
    @(negedge Clk);
    start  = 1'b0;
    guess  = "CRANE";
    target = "CRANE";
    // start and ack while busy must both be ignored
    @(negedge Clk);
    start = 1'b1;
    ack   = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    ack   = 1'b0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge Clk);
      k++;
    end
    n_checks++;
    if (done !== 1'b1 || colors !== 15'b110_111_010_111_010 || win !== 1'b0)
      $display("FAIL start_during_busy: done=%b colors=%b win=%b", done, colors, win);
    else n_pass++;
    // start together with ack in DONE: ack wins, start dropped
    start = 1'b1;
    ack   = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    ack   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy !== 1'b0 || done !== 1'b0 || colors !== 15'b110_111_010_111_010) extra++;
      @(negedge Clk);
    end
    n_checks++;
    if (extra != 0) $display("FAIL start_with_ack: got %0d bad cycles want 0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_mid_score();
    int k;
    int bad = 0;
    @(negedge Clk);
    guess  = "PAPER";
    target = "APPLE";
    start  = 1'b1;
    @(posedge Clk);             // edge N
    #1 start = 1'b0;
    repeat (3) @(posedge Clk);  // edge N+3
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (colors !== 15'h0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_mid: colors=%b busy=%b done=%b want 0 0 0", colors, busy, done);
    else n_pass++;
    @(negedge Clk);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_no_partial: got %0d bad cycles want 0", bad);
    else n_pass++;
    do_score("PAPER", "APPLE", k);
    n_checks++;
    if (k != 7 || colors !== 15'b110_110_010_110_111 || win !== 1'b0)
      $display("FAIL reset_rescore: k=%0d colors=%b win=%b want 7 110110010110111 0",
               k, colors, win);
    else n_pass++;
    do_ack();
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    ack     = 1'b0;
    guess   = '0;
    target  = '0;
    repeat (2) @(negedge Clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge Clk);
    test_apple();
    test_duplicates();
    test_win();
    test_blank_and_case();
    test_timing();
    test_ignored_handshake();
    test_reset_mid_score();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
